// File: rtl/seq_det_param_if.sv
// Bundles the serial stream, configuration and result signals of seq_det_param.
// The master side drives the stream and configuration. The slave side is the detector.
interface seq_det_param_if #(
  parameter int unsigned PAT_LEN = 6,
  parameter int unsigned CNT_W   = 8
);
  logic               din_vld;
  logic               din;
  logic               cfg_we;
  logic [PAT_LEN-1:0] cfg_pat;
  logic [PAT_LEN-1:0] cfg_mask;
  logic               cfg_ovl;
  logic               cnt_clr;
  logic               result;
  logic [CNT_W-1:0]   match_cnt;

  modport master (
    output din_vld, din, cfg_we, cfg_pat, cfg_mask, cfg_ovl, cnt_clr,
    input  result, match_cnt
  );

  modport slave (
    input  din_vld, din, cfg_we, cfg_pat, cfg_mask, cfg_ovl, cnt_clr,
    output result, match_cnt
  );
endinterface

// File: rtl/seq_det_param.sv
// Serial pattern detector with a programmable pattern and don't-care mask.
// Supports overlap and non-overlap modes, and keeps a saturating match counter.
module seq_det_param #(
  parameter int unsigned        PAT_LEN  = 6,
  parameter int unsigned        CNT_W    = 8,
  parameter logic [PAT_LEN-1:0] RST_PAT  = 6'b101100,
  parameter logic [PAT_LEN-1:0] RST_MASK = '1
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_det_param_if.slave bus
);

  localparam int unsigned        FW       = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0]      FILL_MAX = FW'(PAT_LEN);
  localparam logic [FW-1:0]      FILL_HIT = FW'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] hist;
  logic [PAT_LEN-1:0] pat;
  logic [PAT_LEN-1:0] mask;
  logic               ovl;
  logic [FW-1:0]      fill;
  logic               result_q;
  logic [CNT_W-1:0]   cnt_q;

  logic [PAT_LEN-1:0] hn;
  logic               hit;

  // hit is gated by din_vld so that an X on din during gaps cannot reach state
  always_comb begin
    hn  = {hist[PAT_LEN-2:0], bus.din};
    hit = bus.din_vld && !bus.cfg_we && (fill >= FILL_HIT) &&
          (((hn ^ pat) & mask) == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist     <= '0;
      pat      <= RST_PAT;
      mask     <= RST_MASK;
      ovl      <= 1'b1;
      fill     <= '0;
      result_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (bus.cfg_we) begin
        pat      <= bus.cfg_pat;
        mask     <= bus.cfg_mask;
        ovl      <= bus.cfg_ovl;
        fill     <= '0;
        result_q <= 1'b0;
      end else if (bus.din_vld) begin
        hist     <= hn;
        result_q <= hit;
        if (hit && !ovl)
          fill <= '0;
        else if (fill != FILL_MAX)
          fill <= fill + FW'(1);
      end else begin
        result_q <= 1'b0;
      end

      // The clear wins over the old count, but a hit on the same edge is still counted.
      if (bus.cnt_clr)
        cnt_q <= hit ? CNT_W'(1) : '0;
      else if (hit && (cnt_q != '1))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.result    = result_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_param.sv
// Directed self-checking bench for seq_det_param.
// Uses two PAT_LEN=4 instances (counter widths 8 and 2) and one default PAT_LEN=6 instance.
module tb_seq_det_param;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       din_vld, din, cnt_clr;
  logic       cfg_we, cfg_ovl;
  logic [3:0] cfg_pat, cfg_mask;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  seq_det_param_if #(.PAT_LEN(4), .CNT_W(8)) if4  ();
  seq_det_param_if #(.PAT_LEN(4), .CNT_W(2)) if4c ();
  seq_det_param_if #(.PAT_LEN(6), .CNT_W(8)) if6  ();

  assign if4.din_vld  = din_vld;  assign if4.din  = din;  assign if4.cnt_clr  = cnt_clr;
  assign if4.cfg_we   = cfg_we;   assign if4.cfg_pat  = cfg_pat;  assign if4.cfg_mask  = cfg_mask;
  assign if4.cfg_ovl  = cfg_ovl;
  assign if4c.din_vld = din_vld;  assign if4c.din = din;  assign if4c.cnt_clr = cnt_clr;
  assign if4c.cfg_we  = cfg_we;   assign if4c.cfg_pat = cfg_pat;  assign if4c.cfg_mask = cfg_mask;
  assign if4c.cfg_ovl = cfg_ovl;
  assign if6.din_vld  = din_vld;  assign if6.din  = din;  assign if6.cnt_clr  = cnt_clr;
  assign if6.cfg_we   = 1'b0;     assign if6.cfg_pat  = '0;       assign if6.cfg_mask  = '0;
  assign if6.cfg_ovl  = 1'b1;

  seq_det_param #(.PAT_LEN(4), .CNT_W(8), .RST_PAT(4'b1101), .RST_MASK(4'b1111)) u4 (
    .clk(clk), .rst_n(rst_n), .bus(if4));
  seq_det_param #(.PAT_LEN(4), .CNT_W(2), .RST_PAT(4'b1101), .RST_MASK(4'b1111)) u4c (
    .clk(clk), .rst_n(rst_n), .bus(if4c));
  seq_det_param #(.PAT_LEN(6), .CNT_W(8)) u6 (
    .clk(clk), .rst_n(rst_n), .bus(if6));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic v, input logic d, input logic clr);
    @(negedge clk);
    cfg_we = 1'b0; din_vld = v; din = d; cnt_clr = clr;
    @(posedge clk); #1;
  endtask

  // Config edge also presents a valid bit, which must be ignored.
  task automatic cfg(input logic [3:0] p, input logic [3:0] m, input logic o, input logic clr);
    @(negedge clk);
    cfg_we = 1'b1; cfg_pat = p; cfg_mask = m; cfg_ovl = o;
    din_vld = 1'b1; din = 1'b1; cnt_clr = clr;
    @(posedge clk); #1;
    check("cfg_result", 32'(if4.result), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; din_vld = 1'b1; din = 1'b1; cnt_clr = 1'b0; cfg_we = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; din_vld = 1'b0;
  endtask

  initial begin
    logic [6:0] s7, e7;
    logic [7:0] e8;
    logic [3:0] s4;
    logic [5:0] s6, e6;

    rst_n = 1'b0; din_vld = 1'b0; din = 1'b0; cnt_clr = 1'b0;
    cfg_we = 1'b0; cfg_ovl = 1'b0; cfg_pat = '0; cfg_mask = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check("rst_result4", 32'(if4.result), 32'd0);
    check("rst_cnt4", 32'(if4.match_cnt), 32'd0);
    check("rst_cnt6", 32'(if6.match_cnt), 32'd0);

    // Test 1: overlap mode
    cfg(4'b1101, 4'b1111, 1'b1, 1'b1);
    s7 = 7'b1101101; e7 = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      send(1'b1, s7[i], 1'b0);
      check($sformatf("t1_bit%0d", 7 - i), 32'(if4.result), 32'(e7[i]));
    end
    check("t1_cnt", 32'(if4.match_cnt), 32'd2);

    // Test 2: non-overlap mode
    cfg(4'b1101, 4'b1111, 1'b0, 1'b1);
    e7 = 7'b0001000;
    for (int i = 6; i >= 0; i--) begin
      send(1'b1, s7[i], 1'b0);
      check($sformatf("t2_bit%0d", 7 - i), 32'(if4.result), 32'(e7[i]));
    end
    check("t2_cnt", 32'(if4.match_cnt), 32'd1);

    // Test 3: gaps with X data between valid bits
    cfg(4'b1101, 4'b1111, 1'b1, 1'b1);
    e7 = 7'b0001001;
    for (int i = 6; i >= 0; i--) begin
      send(1'b1, s7[i], 1'b0);
      check($sformatf("t3_bit%0d", 7 - i), 32'(if4.result), 32'(e7[i]));
      send(1'b0, 1'bx, 1'b0);
      check($sformatf("t3_gap%0d", 7 - i), 32'(if4.result), 32'd0);
    end
    check("t3_cnt", 32'(if4.match_cnt), 32'd2);

    // Test 4: masked pattern
    cfg(4'b1001, 4'b1011, 1'b1, 1'b1);
    s4 = 4'b1001;
    for (int i = 3; i >= 0; i--) send(1'b1, s4[i], 1'b0);
    check("t4_1001", 32'(if4.result), 32'd1);
    cfg(4'b1001, 4'b1011, 1'b1, 1'b0);
    s4 = 4'b1101;
    for (int i = 3; i >= 0; i--) send(1'b1, s4[i], 1'b0);
    check("t4_1101", 32'(if4.result), 32'd1);
    cfg(4'b1001, 4'b1011, 1'b1, 1'b0);
    s4 = 4'b0001;
    for (int i = 3; i >= 0; i--) send(1'b1, s4[i], 1'b0);
    check("t4_0001", 32'(if4.result), 32'd0);
    check("t4_cnt", 32'(if4.match_cnt), 32'd2);

    // All-zero mask: hit as soon as the window holds PAT_LEN bits
    cfg(4'b0000, 4'b0000, 1'b1, 1'b1);
    s4 = 4'b0101;
    for (int i = 3; i >= 0; i--) begin
      send(1'b1, s4[i], 1'b0);
      check($sformatf("zm_bit%0d", 4 - i), 32'(if4.result), (i == 0) ? 32'd1 : 32'd0);
    end
    send(1'b1, 1'b1, 1'b0);
    check("zm_bit5", 32'(if4.result), 32'd1);
    check("zm_cnt", 32'(if4.match_cnt), 32'd2);

    // Test 5: 2-bit counter saturation, then clear together with a hit
    cfg(4'b1111, 4'b1111, 1'b1, 1'b1);
    e8 = 8'b00011111;
    for (int i = 7; i >= 0; i--) begin
      send(1'b1, 1'b1, 1'b0);
      check($sformatf("t5_bit%0d", 8 - i), 32'(if4c.result), 32'(e8[i]));
    end
    check("t5_sat", 32'(if4c.match_cnt), 32'd3);
    send(1'b1, 1'b1, 1'b1);
    check("t5_clr_hit", 32'(if4c.match_cnt), 32'd1);
    send(1'b0, 1'b0, 1'b1);
    check("t5_clr_nohit", 32'(if4c.match_cnt), 32'd0);

    // Test 6: mid-stream reset discards history
    cfg(4'b1101, 4'b1111, 1'b1, 1'b1);
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    do_reset();
    #1;
    check("t6_rst_cnt", 32'(if4.match_cnt), 32'd0);
    send(1'b1, 1'b1, 1'b0);
    check("t6_no_hit", 32'(if4.result), 32'd0);

    // Default 6-bit pattern after reset
    do_reset();
    s6 = 6'b101100; e6 = 6'b000001;
    for (int i = 5; i >= 0; i--) begin
      send(1'b1, s6[i], 1'b0);
      check($sformatf("t6_p6_bit%0d", 6 - i), 32'(if6.result), 32'(e6[i]));
    end
    check("t6_p6_cnt", 32'(if6.match_cnt), 32'd1);
    send(1'b0, 1'b0, 1'b0);
    check("t6_p6_pulse_end", 32'(if6.result), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
